stream_mux_rr: RTL and testbench
================================

// Module: stream_mux_rr
// PURPOSE
// - N-channel streaming successor to the 4:1 combinational MUX.
// - Selects one of CHANNELS BITS-wide valid/ready input streams into one registered output stream.
// - Two selection modes:
//   - fixed: external channel select;
//   - round-robin: fair arbitration.
// - Sits between parallel CWT scale/filter channels and the shared downstream datapath.
// PARAMETERS
// - BITS      16  data width per channel
// - CHANNELS  4   number of input channels (>=2)
// - SEL_W     $clog2(CHANNELS)  width of select/channel-id fields (derived, do not override)
// PORTS
// - clk           in   1              single clock, rising edge
// - rst_n         in   1              asynchronous, active-low reset
// - in_data       in   CHANNELS*BITS  packed inputs; channel i at [i*BITS +: BITS]
// - in_valid      in   CHANNELS       per-channel valid
// - in_ready      out  CHANNELS       per-channel ready (combinational from state, out_ready, in_valid, mode/sel)
// - mode          in   1              0 = fixed select, 1 = round-robin
// - selection_line in  SEL_W          channel select, used in fixed mode only
// - out_data      out  BITS           registered output data
// - out_valid     out  1              registered output valid
// - out_chan      out  SEL_W          channel id of out_data
// - out_ready     in   1              downstream ready
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - out_data=0, out_valid=0, out_chan=0;
//   - rr pointer = CHANNELS-1, so channel 0 wins first;
//   - lock cleared.
//   - Outputs change immediately on reset assertion.
//   - Any in-flight beat is dropped.
// - load = !out_valid || out_ready.
//   - Output register accepts a new beat only when load=1.
//   - Full throughput: one beat per cycle with out_ready held high.
// - Fixed mode grant:
//   - grant = selection_line iff in_valid[selection_line];
//   - selection_line >= CHANNELS gives no grant (output goes/stays empty).
// - Round-robin grant:
//   - first i with in_valid[i], searching (ptr+1 .. ptr+CHANNELS) mod CHANNELS;
//   - ptr <= granted channel on each accepted beat only;
//   - ptr wraps CHANNELS-1 -> 0.
// - in_ready[i] = load && grant_valid && (grant == i): at most one bit set (one-hot or zero).
// - Transfer on in_valid[g] && in_ready[g]:
//   - next cycle out_data = channel g data, out_chan = g, out_valid = 1.
//   - Latency is exactly 1 cycle from input transfer to out_valid.
// - load=1 and no grant: out_valid <= 0; out_data and out_chan hold last values.
// - out_valid=1 and out_ready=0: out_data, out_chan and out_valid hold stable; all in_ready=0.
// - Simultaneous output pop and new grant in the same cycle: register replaced, no bubble.
// - mode/selection_line changes take effect on the next arbitration cycle.
//   - No beat is lost or duplicated.
//   - In fixed mode, the rr pointer holds.
// CONFIGURATION
// - Macro STREAM_MUX_PKT_LOCK_EN.
// - Defined:
//   - adds input port in_last [CHANNELS] and output port out_last [1];
//   - out_last is registered with the data;
//   - once a channel is granted, the grant is locked to it until its beat with in_last=1 transfers;
//   - mode/selection_line changes and other valid channels are ignored while locked;
//   - RR pointer advances only on the last beat;
//   - reset clears the lock; out_last resets to 0.
// - Undefined:
//   - no in_last/out_last ports;
//   - arbitration is re-evaluated every beat, as described above.
// TESTING
// - Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid, out_data, out_chan = 0 immediately; after release, first RR grant is ch0.
// - Fixed mode, sel=2, all valid, ch2 data 16'h00A2, out_ready=1 -> out_data=16'h00A2, out_chan=2 one cycle later; in_ready=4'b0100.
// - Fixed mode, sel=2, in_valid[2]=0 -> in_ready=0, out_valid falls to 0 next cycle.
// - RR, all 4 valid continuously, out_ready=1 -> out_chan sequence 0,1,2,3,0,1... with one beat per cycle.
// - RR, valid=4'b1010 -> alternating 1,3,1,3.
// - Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> out_data, out_chan stable, in_ready=0; release -> next beat follows with no gap or loss.
// - PKT_LOCK_EN, RR, ch1 sends 3-beat packet (last on beat 3) while ch0/ch2 valid -> three ch1 beats back-to-back, then ch2.

Source files
------------

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready stream multiplexer with a registered output.
// The output stream is fed from either a fixed, externally selected channel or
// a round-robin arbiter. Optional packet locking is enabled by the macro
// STREAM_MUX_PKT_LOCK_EN. Once a channel is granted, the grant stays with that
// channel until its in_last beat transfers.
//
// Handshake: a beat moves across an interface on a rising clock edge where
// valid and ready are both high. A producer holds valid and its data stable
// until that beat transfers. in_ready is combinational and never depends on
// the data of the requesting channel. out_valid/out_data/out_chan are registered.
module stream_mux_rr #(
    parameter int BITS      = 16,
    parameter int CHANNELS  = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CHANNELS*BITS-1:0] in_data,
    input  logic [CHANNELS-1:0]      in_valid,
`ifdef STREAM_MUX_PKT_LOCK_EN
    input  logic [CHANNELS-1:0]      in_last,
`endif
    output logic [CHANNELS-1:0]      in_ready,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         selection_line,
    output logic [BITS-1:0]          out_data,
    output logic                     out_valid,
    output logic [SEL_W-1:0]         out_chan,
`ifdef STREAM_MUX_PKT_LOCK_EN
    output logic                     out_last,
`endif
    input  logic                     out_ready
);

    logic             load;
    logic             accept;
    logic             ptr_adv;
    logic [SEL_W-1:0] rr_ptr;
    logic             fix_valid;
    logic [SEL_W-1:0] fix_grant;
    logic             rr_valid;
    logic [SEL_W-1:0] rr_grant;
    logic             grant_valid;
    logic [SEL_W-1:0] grant;
    logic [BITS-1:0]  grant_data;

`ifdef STREAM_MUX_PKT_LOCK_EN
    logic             lock_active;
    logic [SEL_W-1:0] lock_chan;
    logic             lock_rr;
    logic             grant_last;
`endif

    // The output register may take a new beat when it is empty or being popped.
    assign load   = !out_valid || out_ready;
    assign accept = load && grant_valid;

    // Fixed-mode candidate: an out-of-range select matches no channel.
    always_comb begin
        logic [SEL_W-1:0] idx;
        fix_valid = 1'b0;
        fix_grant = '0;
        idx       = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            idx = SEL_W'(i);
            if (selection_line == idx && in_valid[idx]) begin
                fix_valid = 1'b1;
                fix_grant = idx;
            end
        end
    end

    // Round-robin candidate: first valid channel after the pointer, wrapping.
    always_comb begin
        logic [SEL_W-1:0] idx;
        rr_valid = 1'b0;
        rr_grant = '0;
        idx      = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            idx = SEL_W'((int'(rr_ptr) + k) % CHANNELS);
            if (!rr_valid && in_valid[idx]) begin
                rr_valid = 1'b1;
                rr_grant = idx;
            end
        end
    end

    // Final grant: a held packet lock overrides mode and select.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
        if (lock_active) begin
            grant       = lock_chan;
            grant_valid = in_valid[lock_chan];
        end else if (mode) begin
            grant       = rr_grant;
            grant_valid = rr_valid;
        end else begin
            grant       = fix_grant;
            grant_valid = fix_valid;
        end
`else
        if (mode) begin
            grant       = rr_grant;
            grant_valid = rr_valid;
        end else begin
            grant       = fix_grant;
            grant_valid = fix_valid;
        end
`endif
    end

    // Data steering and one-hot ready generation for the granted channel.
    always_comb begin
        grant_data = '0;
        in_ready   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant == SEL_W'(i)) begin
                grant_data  = in_data[i*BITS +: BITS];
                in_ready[i] = accept;
            end
        end
    end

`ifdef STREAM_MUX_PKT_LOCK_EN
    assign grant_last = in_last[grant];
    // The pointer moves only when a packet completes. It follows the mode that
    // was in force when the packet was first granted.
    assign ptr_adv = accept && grant_last && (lock_active ? lock_rr : mode);

    // Packet lock: taken on a non-last beat, released on the last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_active <= 1'b0;
            lock_chan   <= '0;
            lock_rr     <= 1'b0;
        end else if (accept) begin
            if (grant_last) begin
                lock_active <= 1'b0;
            end else if (!lock_active) begin
                lock_active <= 1'b1;
                lock_chan   <= grant;
                lock_rr     <= mode;
            end
        end
    end
`else
    assign ptr_adv = accept && mode;
`endif

    // Round-robin pointer. After reset it points at the last channel, so channel 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= SEL_W'(CHANNELS - 1);
        end else if (ptr_adv) begin
            rr_ptr <= grant;
        end
    end

    // Output register: replaced on accept, emptied when popped with no grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
            out_last  <= 1'b0;
`endif
        end else if (load) begin
            if (grant_valid) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_chan  <= grant;
`ifdef STREAM_MUX_PKT_LOCK_EN
                out_last  <= grant_last;
`endif
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: table-driven vectors, hand sequences (reset, backpressure,
// packet lock when STREAM_MUX_PKT_LOCK_EN is defined) and randomized traffic
// against a rule-level reference model with an expected-beat queue.
module tb_stream_mux_rr;

    localparam int BITS  = 16;
    localparam int CH    = 4;
    localparam int SEL_W = 2;

    logic              clk;
    logic              rst_n;
    logic [CH*BITS-1:0] in_data;
    logic [CH-1:0]     in_valid;
    logic [CH-1:0]     in_ready;
    logic              mode;
    logic [SEL_W-1:0]  selection_line;
    logic [BITS-1:0]   out_data;
    logic              out_valid;
    logic [SEL_W-1:0]  out_chan;
    logic              out_ready;
`ifdef STREAM_MUX_PKT_LOCK_EN
    logic [CH-1:0]     in_last;
    logic              out_last;
`endif

    stream_mux_rr #(.BITS(BITS), .CHANNELS(CH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_data        (in_data),
        .in_valid       (in_valid),
`ifdef STREAM_MUX_PKT_LOCK_EN
        .in_last        (in_last),
`endif
        .in_ready       (in_ready),
        .mode           (mode),
        .selection_line (selection_line),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_chan       (out_chan),
`ifdef STREAM_MUX_PKT_LOCK_EN
        .out_last       (out_last),
`endif
        .out_ready      (out_ready)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic             m_valid;
    logic [BITS-1:0]  m_data;
    logic [SEL_W-1:0] m_chan;
    int               m_ptr;
    logic [SEL_W+BITS-1:0] exp_q[$];

    typedef struct {
        logic             md;
        logic [SEL_W-1:0] sl;
        logic [CH-1:0]    vl;
        logic             ordy;
        logic [CH-1:0]    exp_ready;
        logic             exp_ovalid;
        logic [SEL_W-1:0] exp_chan;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, want);
        end
    endtask

    // The first eligible channel, taken in the order ptr+1, ptr+2, ... wrapping.
    function automatic int pick_rr(input int ptr, input logic [CH-1:0] v);
        int order[$];
        for (int k = 1; k <= CH; k++) order.push_back((ptr + k) % CH);
        foreach (order[j]) if (v[2'(order[j])]) return order[j];
        return -1;
    endfunction

    task automatic do_reset();
        in_valid = '0;
        out_ready = 1'b0;
        mode = 1'b0;
        selection_line = '0;
        rst_n = 1'b0;
        #1;
        chk("reset out_valid", 32'(out_valid), 0);
        chk("reset out_data", 32'(out_data), 0);
        chk("reset out_chan", 32'(out_chan), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_valid = 1'b0;
        m_data = '0;
        m_chan = '0;
        m_ptr = CH - 1;
        exp_q.delete();
    endtask

    // Drive one cycle, then compare against hand-written expectations. Data of channel i is 16'h00A0+i.
    task automatic drive_check(input string nm, input logic md, input logic [SEL_W-1:0] sl,
                               input logic [CH-1:0] vl, input logic ordy, input logic [CH-1:0] er,
                               input logic eov, input logic [SEL_W-1:0] ech);
        mode = md;
        selection_line = sl;
        in_valid = vl;
        out_ready = ordy;
        @(negedge clk);
        chk({nm, " in_ready"}, 32'(in_ready), 32'(er));
        @(posedge clk);
        #1;
        chk({nm, " out_valid"}, 32'(out_valid), 32'(eov));
        chk({nm, " out_chan"}, 32'(out_chan), 32'(ech));
        chk({nm, " out_data"}, 32'(out_data), 32'h00A0 + 32'(ech));
    endtask

    // One cycle of model-checked traffic.
    task automatic m_step(input logic md, input logic [SEL_W-1:0] sl, input logic [CH-1:0] vl,
                          input logic [CH*BITS-1:0] dat, input logic ordy);
        logic ld;
        int g;
        logic [CH-1:0] er;
        logic [SEL_W+BITS-1:0] item;
        mode = md;
        selection_line = sl;
        in_valid = vl;
        in_data = dat;
        out_ready = ordy;
        @(negedge clk);
        ld = !m_valid || ordy;
        if (md) g = pick_rr(m_ptr, vl);
        else g = vl[sl] ? int'(sl) : -1;
        er = (ld && g >= 0) ? 4'(1 << g) : 4'b0;
        chk("model in_ready", 32'(in_ready), 32'(er));
        chk("model out_valid", 32'(out_valid), 32'(m_valid));
        chk("model out_chan", 32'(out_chan), 32'(m_chan));
        chk("model out_data", 32'(out_data), 32'(m_data));
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb unexpected beat: got chan %0d data %0h, expected none", out_chan, out_data);
            end else begin
                item = exp_q.pop_front();
                chk("sb beat", 32'({out_chan, out_data}), 32'(item));
            end
        end
        @(posedge clk);
        if (ld) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_chan = SEL_W'(g);
                m_data = dat[g*BITS +: BITS];
                exp_q.push_back({m_chan, m_data});
                if (md) m_ptr = g;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    function automatic logic [CH*BITS-1:0] rand_data();
        logic [CH*BITS-1:0] d;
        for (int i = 0; i < CH; i++) d[i*BITS +: BITS] = BITS'($urandom);
        return d;
    endfunction

    logic [CH*BITS-1:0] tbl_data;
    logic [CH*BITS-1:0] bp_data;

    initial begin
        rst_n = 1'b1;
        in_data = '0;
        in_valid = '0;
        out_ready = 1'b0;
        mode = 1'b0;
        selection_line = '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
        in_last = 4'hF;
`endif
        tbl_data = {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};

        //               md    sl    valid    ordy  ready    ov    chan
        vecs[0]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
        vecs[1]  = '{1'b0, 2'd2, 4'b1011, 1'b1, 4'b0000, 1'b0, 2'd2};
        vecs[2]  = '{1'b0, 2'd3, 4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3};
        vecs[3]  = '{1'b0, 2'd3, 4'b1000, 1'b0, 4'b0000, 1'b1, 2'd3};
        vecs[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        vecs[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
        vecs[7]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
        vecs[8]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[9]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1};
        vecs[10] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3};
        vecs[11] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1};
        vecs[12] = '{1'b1, 2'd0, 4'b1010, 1'b0, 4'b0000, 1'b1, 2'd1};
        vecs[13] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3};
        vecs[14] = '{1'b0, 2'd1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3};
        vecs[15] = '{1'b0, 2'd1, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1};

        #2;
        do_reset();

        // Table-driven vectors
        in_data = tbl_data;
        for (int i = 0; i < 16; i++) begin
            drive_check($sformatf("vec%0d", i), vecs[i].md, vecs[i].sl, vecs[i].vl, vecs[i].ordy,
                        vecs[i].exp_ready, vecs[i].exp_ovalid, vecs[i].exp_chan);
        end

        // Reset asserted mid-stream while out_valid=1
        mode = 1'b1;
        in_valid = 4'hF;
        out_ready = 1'b1;
        #3;
        do_reset();

        // First round-robin grant after reset is channel 0
        m_step(1'b1, 2'd0, 4'hF, tbl_data, 1'b1);
        chk("post-reset first rr chan", 32'(out_chan), 0);
        chk("post-reset first rr valid", 32'(out_valid), 1);

        // Backpressure: hold for 5 cycles, then release with no gap or loss
        bp_data = {16'h3333, 16'h2222, 16'h1111, 16'hBEEF};
        m_step(1'b0, 2'd0, 4'hF, bp_data, 1'b1);
        for (int i = 0; i < 5; i++) begin
            m_step(1'b1, 2'd0, 4'hF, bp_data, 1'b0);
            chk("bp out_data stable", 32'(out_data), 32'hBEEF);
            chk("bp out_chan stable", 32'(out_chan), 0);
            chk("bp out_valid held", 32'(out_valid), 1);
        end
        m_step(1'b1, 2'd0, 4'hF, bp_data, 1'b1);
        chk("bp release next chan", 32'(out_chan), 1);
        chk("bp release next data", 32'(out_data), 32'h1111);

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            m_step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                   rand_data(), $urandom_range(0, 3) != 0);
        end

        // Drain and confirm every expected beat was delivered
        for (int n = 0; n < 4; n++) m_step(1'b1, 2'd0, 4'h0, '0, 1'b1);
        chk("sb queue empty", 32'(exp_q.size()), 0);

`ifdef STREAM_MUX_PKT_LOCK_EN
        // Packet lock: ch1 three-beat packet holds the grant while ch0/ch2 wait
        do_reset();
        in_data = tbl_data;
        in_last = 4'b0001;
        drive_check("lock a", 1'b1, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0);
        in_last = 4'b0000;
        drive_check("lock b", 1'b1, 2'd0, 4'b0111, 1'b1, 4'b0010, 1'b1, 2'd1);
        drive_check("lock c", 1'b1, 2'd0, 4'b0111, 1'b1, 4'b0010, 1'b1, 2'd1);
        chk("lock c out_last", 32'(out_last), 0);
        in_last = 4'b0010;
        drive_check("lock d", 1'b1, 2'd0, 4'b0111, 1'b1, 4'b0010, 1'b1, 2'd1);
        chk("lock d out_last", 32'(out_last), 1);
        in_last = 4'b1111;
        drive_check("lock e", 1'b1, 2'd0, 4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
